fp_issue_ctrl: RTL and testbench

Initiator-side controller for the floating-point add/subtract unit's operand/result handshake. It buffers operation requests from the upstream pipeline in a small FIFO and issues them one at a time to the unit on `iready`/`uready`. It then collects each result on `rready`/`rtaken` and presents it downstream on a valid/ready port, together with the NaN/Inf/Error flags and a request tag. A watchdog counter converts a hung operation into a flagged timeout response.

---
 rtl/fp_pkg.sv | 30 +++
 rtl/fp_req_fifo.sv | 65 ++++++
 rtl/fp_issue_ctrl.sv | 175 +++++++++++++++++
 tb/tb_fp_issue_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared types for the floating-point add/sub issue controller.
// The tag field width is fixed here; fp_issue_ctrl's TAG_W should match it.
package fp_pkg;

  localparam int unsigned FpTagW = 4;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StTake
  } fp_issue_state_t;

  typedef struct packed {
    logic [31:0]       op_a;
    logic [31:0]       op_b;
    logic              sub;
    logic [FpTagW-1:0] tag;
  } fp_req_t;

  typedef struct packed {
    logic [31:0]       data;
    logic              nan;
    logic              inf;
    logic              err;
    logic              timeout;
    logic [FpTagW-1:0] tag;
  } fp_resp_t;

endpackage

// File: rtl/fp_req_fifo.sv
// Synchronous request FIFO; pointers wrap naturally, count is one bit wider than the pointers.
module fp_req_fifo
  import fp_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    push_i,
  input  fp_req_t wdata_i,
  input  logic    pop_i,
  output fp_req_t rdata_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  fp_req_t         mem_q [Depth];
  fp_req_t         mem_d [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign full_o  = (cnt_q == (PtrW + 1)'(Depth));
  assign empty_o = (cnt_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    cnt_d = cnt_q + (PtrW + 1)'(do_push) - (PtrW + 1)'(do_pop);
  end

  // Storage needs no reset: entries are only read once the count says they were written.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/fp_issue_ctrl.sv
// Issues buffered add/sub requests to the FP unit one at a time and returns each result,
// or a timeout response if the unit hangs, on a registered valid/ready port.
module fp_issue_ctrl
  import fp_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = FpTagW,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_opA,
  input  logic [31:0]      req_opB,
  input  logic             req_sub,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      opA,
  output logic [31:0]      opB,
  output logic             in_sel,
  output logic             iready,
  input  logic             uready,
  input  logic [31:0]      rout,
  input  logic             NaN_out,
  input  logic             Inf_out,
  input  logic             Error_out,
  input  logic             rready,
  output logic             rtaken,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic             res_nan,
  output logic             res_inf,
  output logic             res_err,
  output logic             res_timeout,
  output logic [TAG_W-1:0] res_tag
);

  localparam int unsigned WdW = $clog2(TIMEOUT + 1);

  fp_issue_state_t state_q, state_d;
  logic [WdW-1:0]  wd_q, wd_d;
  logic [31:0]     op_a_q, op_a_d, op_b_q, op_b_d;
  logic            in_sel_q, in_sel_d;
  logic            iready_q, iready_d;
  logic            rtaken_q, rtaken_d;
  logic [FpTagW-1:0] tag_q, tag_d;
  fp_resp_t        res_q, res_d;
  logic            res_valid_q, res_valid_d;

  fp_req_t fifo_wdata, fifo_head;
  logic    fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic    res_free;

  assign req_ready  = !fifo_full;
  assign fifo_push  = req_valid && !fifo_full;
  assign fifo_wdata = '{op_a: req_opA, op_b: req_opB, sub: req_sub, tag: FpTagW'(req_tag)};

  fp_req_fifo #(
    .Depth (DEPTH)
  ) u_req_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign res_free = !res_valid_q || res_ready;

  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    in_sel_d    = in_sel_q;
    iready_d    = iready_q;
    rtaken_d    = 1'b0;
    tag_d       = tag_q;
    fifo_pop    = 1'b0;
    res_d       = res_q;
    res_valid_d = res_valid_q && !res_ready;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          // Operands are registered on entry so they stay stable for the whole ISSUE phase.
          op_a_d   = fifo_head.op_a;
          op_b_d   = fifo_head.op_b;
          in_sel_d = fifo_head.sub;
          iready_d = 1'b1;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        if (uready) begin
          fifo_pop = 1'b1;
          tag_d    = fifo_head.tag;
          wd_d     = '0;
          iready_d = 1'b0;
          state_d  = StWait;
        end
      end
      StWait: begin
        if (rready && res_free) begin
          res_d       = '{data: rout, nan: NaN_out, inf: Inf_out, err: Error_out,
                          timeout: 1'b0, tag: tag_q};
          res_valid_d = 1'b1;
          rtaken_d    = 1'b1;
          state_d     = StTake;
        end else if (rready) begin
          // Result waiting on a full response register: hold and freeze the watchdog.
          wd_d = wd_q;
        end else if (wd_q == WdW'(TIMEOUT - 1)) begin
          if (res_free) begin
            res_d       = '{data: '0, nan: 1'b0, inf: 1'b0, err: 1'b0, timeout: 1'b1, tag: tag_q};
            res_valid_d = 1'b1;
            state_d     = StIdle;
          end
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      StTake: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      wd_q        <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      in_sel_q    <= 1'b0;
      iready_q    <= 1'b0;
      rtaken_q    <= 1'b0;
      tag_q       <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      in_sel_q    <= in_sel_d;
      iready_q    <= iready_d;
      rtaken_q    <= rtaken_d;
      tag_q       <= tag_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign opA         = op_a_q;
  assign opB         = op_b_q;
  assign in_sel      = in_sel_q;
  assign iready      = iready_q;
  assign rtaken      = rtaken_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_q.data;
  assign res_nan     = res_q.nan;
  assign res_inf     = res_q.inf;
  assign res_err     = res_q.err;
  assign res_timeout = res_q.timeout;
  assign res_tag     = TAG_W'(res_q.tag);

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Scoreboard bench for fp_issue_ctrl with a behavioural FP unit model.
module tb_fp_issue_ctrl;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TAG_W   = 4;
  localparam int unsigned TIMEOUT = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid, req_ready, req_sub;
  logic [31:0]      req_opA, req_opB;
  logic [TAG_W-1:0] req_tag;
  logic [31:0]      opA, opB, rout, res_data;
  logic             in_sel, iready, uready, rready, rtaken;
  logic             NaN_out, Inf_out, Error_out;
  logic             res_valid, res_ready, res_nan, res_inf, res_err, res_timeout;
  logic [TAG_W-1:0] res_tag;

  always #5 clk = ~clk;

  fp_issue_ctrl #(
    .DEPTH   (DEPTH),
    .TAG_W   (TAG_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_opA     (req_opA),
    .req_opB     (req_opB),
    .req_sub     (req_sub),
    .req_tag     (req_tag),
    .opA         (opA),
    .opB         (opB),
    .in_sel      (in_sel),
    .iready      (iready),
    .uready      (uready),
    .rout        (rout),
    .NaN_out     (NaN_out),
    .Inf_out     (Inf_out),
    .Error_out   (Error_out),
    .rready      (rready),
    .rtaken      (rtaken),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_nan     (res_nan),
    .res_inf     (res_inf),
    .res_err     (res_err),
    .res_timeout (res_timeout),
    .res_tag     (res_tag)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0]      data;
    logic             nan;
    logic             inf;
    logic             err;
    logic             tmo;
    logic [TAG_W-1:0] tag;
  } exp_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
  } iss_t;

  exp_t resp_q[$];
  iss_t iss_q[$];

  // Behaviour of the FP unit: {nan, inf, err, data}. Known IEEE cases are exact.
  function automatic logic [34:0] unit_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic sub);
    logic [31:0] d;
    if (a == 32'h3F800000 && b == 32'h40000000 && !sub) return {3'b000, 32'h40400000};
    if (a == 32'h40400000 && b == 32'h3F800000 && sub)  return {3'b000, 32'h40000000};
    if (a == 32'h7F800000 && b == 32'hFF800000 && !sub) return {3'b100, 32'h7FC00000};
    d = a ^ {b[15:0], b[31:16]} ^ {31'b0, sub};
    return {d[31] & d[30], d[29] & d[28], d[27] & d[26], d};
  endfunction

  // FP unit model
  logic        uready_en, hang, u_busy;
  int          u_lat, u_cnt;
  logic [34:0] u_res;
  assign uready = uready_en && !u_busy;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      u_busy <= 1'b0; rready <= 1'b0; u_cnt <= 0; u_res <= '0;
      rout <= '0; NaN_out <= 1'b0; Inf_out <= 1'b0; Error_out <= 1'b0;
    end else begin
      if (rready && rtaken) begin
        rready <= 1'b0;
        u_busy <= 1'b0;
      end else if (u_busy && !rready) begin
        if (u_cnt <= 1) begin
          rready <= 1'b1;
          {NaN_out, Inf_out, Error_out, rout} <= u_res;
        end else begin
          u_cnt <= u_cnt - 1;
        end
      end
      if (iready && uready && !hang) begin
        u_busy <= 1'b1;
        u_res  <= unit_fn(opA, opB, in_sel);
        u_cnt  <= (u_lat == 0) ? int'($urandom_range(1, 6)) : u_lat;
      end
    end
  end

  // Monitor: samples on the falling edge what the next rising edge will act on.
  logic rt_prev = 1'b0, free_prev = 1'b1, rv_prev = 1'b0, ir_prev = 1'b0;
  int   cyc = 0, issue_cyc = 0, rt_pulses = 0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      if (iready && uready) begin
        if (iss_q.size() == 0) begin
          check("issue_unexpected", 1, 0);
        end else begin
          iss_t e;
          e = iss_q.pop_front();
          check("issue_opA", opA, e.a);
          check("issue_opB", opB, e.b);
          check("issue_in_sel", in_sel, e.sub);
        end
      end
      if (ir_prev && !iready) issue_cyc = cyc;
      if (rtaken) begin
        check("rtaken_single", rt_prev, 0);
        if (!rt_prev) begin
          rt_pulses++;
          check("rtaken_reg_free", free_prev, 1);
          check("rtaken_with_result", {res_valid, res_timeout}, 2'b10);
        end
      end
      if (res_valid && !rv_prev && res_timeout)
        check("timeout_latency", cyc - issue_cyc, TIMEOUT);
      if (res_valid && res_ready) begin
        if (resp_q.size() == 0) begin
          check("resp_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = resp_q.pop_front();
          check("resp", {res_data, res_nan, res_inf, res_err, res_timeout, res_tag}, e);
        end
      end
    end
    rt_prev   = rtaken;
    free_prev = !res_valid || res_ready;
    rv_prev   = res_valid;
    ir_prev   = iready;
  end

  logic bp_rand = 1'b0;
  always @(posedge clk) begin
    if (bp_rand) begin
      #1 res_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic drive_req(input logic [31:0] a, input logic [31:0] b, input logic sub,
                           input logic [TAG_W-1:0] tag);
    @(posedge clk);
    #1;
    req_valid = 1'b1; req_opA = a; req_opB = b; req_sub = sub; req_tag = tag;
  endtask

  task automatic wait_accept();
    logic ok;
    logic [34:0] r;
    int n = 0;
    forever begin
      @(negedge clk) ok = req_ready;
      @(posedge clk);
      if (ok) break;
      n++;
      if (n > 300) begin
        check("accept_timeout", 0, 1);
        break;
      end
    end
    if (ok) begin
      r = unit_fn(req_opA, req_opB, req_sub);
      iss_q.push_back('{a: req_opA, b: req_opB, sub: req_sub});
      if (hang) resp_q.push_back('{data: '0, nan: 0, inf: 0, err: 0, tmo: 1, tag: req_tag});
      else resp_q.push_back('{data: r[31:0], nan: r[34], inf: r[33], err: r[32], tmo: 0,
                              tag: req_tag});
    end
    #1 req_valid = 1'b0;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic sub,
                      input logic [TAG_W-1:0] tag);
    drive_req(a, b, sub, tag);
    wait_accept();
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((resp_q.size() != 0 || iss_q.size() != 0) && n < max) begin
      @(posedge clk);
      n++;
    end
    if (n >= max) check("drain_timeout", resp_q.size(), 0);
    repeat (3) @(posedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_iready"}, iready, 0);
    check({tag, "_rtaken"}, rtaken, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_ops"}, {opA, opB, in_sel}, 0);
    check({tag, "_res_data"}, res_data, 0);
    check({tag, "_res_flags"}, {res_nan, res_inf, res_err, res_timeout}, 0);
    check({tag, "_res_tag"}, res_tag, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int rt0;
    reset = 1'b0; req_valid = 1'b0; req_opA = '0; req_opB = '0; req_sub = 1'b0;
    req_tag = '0; res_ready = 1'b1; uready_en = 1'b1; hang = 1'b0; u_lat = 5;
    #12;
    check_reset_outputs("reset");
    @(negedge clk) reset = 1'b1;

    // Add, with first-issue latency
    push(32'h3F800000, 32'h40000000, 1'b0, 4'd3);
    @(posedge clk);
    #1 check("iready_latency", iready, 1);
    wait_idle(100);

    // Subtract, then NaN flag
    push(32'h40400000, 32'h3F800000, 1'b1, 4'd7);
    wait_idle(100);
    push(32'h7F800000, 32'hFF800000, 1'b0, 4'd5);
    wait_idle(100);

    // FIFO full with the unit refusing operands
    @(posedge clk);
    #1 uready_en = 1'b0;
    for (int i = 0; i < 4; i++) push($urandom, $urandom, 1'($urandom), 4'(i));
    drive_req($urandom, $urandom, 1'b0, 4'd4);
    repeat (3) begin
      @(negedge clk) check("fifo_full_req_ready", req_ready, 0);
    end
    @(posedge clk);
    #1 uready_en = 1'b1;
    wait_accept();
    wait_idle(300);

    // Hung unit: timeout response, no rtaken
    hang = 1'b1;
    rt0 = rt_pulses;
    push($urandom, $urandom, 1'b0, 4'd9);
    wait_idle(200);
    check("timeout_no_rtaken", rt_pulses, rt0);
    @(negedge clk) check("timeout_back_idle", iready, 0);
    hang = 1'b0;

    // Random traffic with random latency and backpressure
    u_lat = 0;
    bp_rand = 1'b1;
    repeat (40) push($urandom, $urandom, 1'($urandom), 4'($urandom));
    wait_idle(3000);
    bp_rand = 1'b0;
    repeat (2) @(posedge clk);
    #2 res_ready = 1'b1;
    wait_idle(100);

    // Backpressure with two results pending, then reset mid-WAIT
    u_lat = 3;
    res_ready = 1'b0;
    push(32'h11111111, 32'h22222222, 1'b0, 4'd1);
    push(32'h33333333, 32'h44444444, 1'b1, 4'd2);
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("bp_res_valid", res_valid, 1);
    check("bp_rtaken_withheld", rtaken, 0);
    check("bp_first_tag", res_tag, 1);
    @(posedge clk);
    #3 reset = 1'b0;
    #1 check_reset_outputs("async_reset");
    resp_q.delete();
    iss_q.delete();
    @(negedge clk);
    res_ready = 1'b1;
    reset = 1'b1;

    // Recovery after reset
    push(32'h3F800000, 32'h40000000, 1'b0, 4'd6);
    wait_idle(100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
